// File: rtl/scpu_pkg.sv
// Shared SCPU definitions: widths, loader limits and loader state encoding.
package scpu_pkg;

    localparam int ADDR_W         = 8;
    localparam int INS_W          = 16;
    localparam int LOAD_MAX_WORDS = 128;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } load_state_t;

    function automatic logic is_busy(input load_state_t s);
        return (s == COUNT) || (s == HI) || (s == LO) || (s == CSUM);
    endfunction

endpackage

// File: rtl/scpu_prog_loader.sv
// Framed byte-stream loader that writes big-endian 16-bit words into SCPU memory.
module scpu_prog_loader
    import scpu_pkg::*;
#(
    parameter int MAX_WORDS = LOAD_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ins_index,
    output logic              ins_we,
    output logic [INS_W-1:0]  instructs,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [7:0]        words_loaded
);

    localparam logic [8:0] MAXW = 9'(MAX_WORDS);

    load_state_t state, next_state;

    logic [7:0] count_q;
    logic [7:0] hi_q;
    logic [7:0] csum_q;
    logic [6:0] word_no;

    logic accept;
    logic cnt_ok;
    logic last_word;
    logic new_frame;

    assign accept    = in_valid && in_ready;
    assign cnt_ok    = (in_data != 8'd0) && ({1'b0, in_data} <= MAXW);
    assign last_word = (({1'b0, word_no}) + 8'd1) == count_q;
    assign new_frame = start && !is_busy(state);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE, ERR: if (start) next_state = COUNT;
            COUNT: if (accept) next_state = cnt_ok ? HI : ERR;
            HI:    if (accept) next_state = LO;
            LO:    if (accept) next_state = last_word ? CSUM : HI;
            CSUM:  if (accept) next_state = (in_data == csum_q) ? DONE : ERR;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            cpu_hold     <= 1'b0;
            ins_we       <= 1'b0;
            ins_index    <= '0;
            instructs    <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            count_q      <= '0;
            hi_q         <= '0;
            csum_q       <= '0;
            word_no      <= '0;
        end else begin
            state    <= next_state;
            in_ready <= is_busy(next_state);
            cpu_hold <= is_busy(next_state);
            ins_we   <= 1'b0;

            if (new_frame) begin
                done         <= 1'b0;
                err          <= 1'b0;
                words_loaded <= '0;
                csum_q       <= '0;
                word_no      <= '0;
            end

            if (accept) begin
                unique case (state)
                    COUNT: count_q <= in_data;
                    HI: begin
                        hi_q   <= in_data;
                        csum_q <= csum_q ^ in_data;
                    end
                    LO: begin
                        csum_q       <= csum_q ^ in_data;
                        ins_we       <= 1'b1;
                        instructs    <= {hi_q, in_data};
                        ins_index    <= {word_no, 1'b0};
                        word_no      <= word_no + 7'd1;
                        words_loaded <= words_loaded + 8'd1;
                    end
                    default: ;
                endcase
            end

            // Flags latch on entry and stay until the next frame starts.
            if (next_state == DONE && state != DONE) done <= 1'b1;
            if (next_state == ERR && state != ERR) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_scpu_prog_loader.sv
// Directed scoreboard bench for scpu_prog_loader.
module tb_scpu_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  ins_index;
    logic        ins_we;
    logic [15:0] instructs;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [7:0]  words_loaded;

    typedef struct {
        logic [7:0]  idx;
        logic [15:0] dat;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  n_writes = 0;

    always #5 clk = ~clk;

    scpu_prog_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ins_index    (ins_index),
        .ins_we       (ins_we),
        .instructs    (instructs),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (ins_we === 1'b1) begin
            wr_t e;
            n_writes++;
            if (exp_q.size() == 0) begin
                chk("unexpected_we", {24'd0, ins_index}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_index", {24'd0, ins_index}, {24'd0, e.idx});
                chk("wr_data", {16'd0, instructs}, {16'd0, e.dat});
            end
        end
    end

    // Entered and left at a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap,
                             input logic st);
        int cnt;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        start    = st;
        cnt      = 0;
        while (in_ready !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_wr(input logic [7:0] idx, input logic [15:0] dat);
        wr_t e;
        e.idx = idx;
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    task automatic nominal(input logic [7:0] csum_byte, input logic st_mid);
        pulse_start();
        push_wr(8'h00, 16'h1234);
        push_wr(8'h02, 16'hABCD);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        send_byte(8'hAB, 0, st_mid);
        send_byte(8'hCD, 0, 1'b0);
        send_byte(csum_byte, 0, 1'b0);
    endtask

    initial begin
        int base;
        logic [7:0] x;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_flags", {30'd0, done, err}, 32'd0);
        chk("rst_outs", {ins_index, instructs, words_loaded}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal frame
        nominal(8'h40, 1'b0);
        chk("nom_done", {31'd0, done}, 32'd1);
        chk("nom_err", {31'd0, err}, 32'd0);
        chk("nom_words", {24'd0, words_loaded}, 32'd2);
        chk("nom_hold", {31'd0, cpu_hold}, 32'd0);
        chk("nom_ready", {31'd0, in_ready}, 32'd0);
        chk("nom_q", exp_q.size(), 32'd0);

        // Bad checksum
        nominal(8'h41, 1'b0);
        chk("bad_err", {31'd0, err}, 32'd1);
        chk("bad_done", {31'd0, done}, 32'd0);
        chk("bad_q", exp_q.size(), 32'd0);

        // Range errors
        base = n_writes;
        pulse_start();
        chk("start_clr", {30'd0, done, err}, 32'd0);
        chk("start_hold", {31'd0, cpu_hold}, 32'd1);
        send_byte(8'h00, 0, 1'b0);
        chk("zero_err", {31'd0, err}, 32'd1);
        chk("zero_hold", {31'd0, cpu_hold}, 32'd0);
        pulse_start();
        send_byte(8'h81, 0, 1'b0);
        chk("big_err", {31'd0, err}, 32'd1);
        chk("big_words", {24'd0, words_loaded}, 32'd0);
        chk("range_nowr", n_writes - base, 32'd0);

        // Full frame with random back-pressure
        pulse_start();
        send_byte(8'h80, 0, 1'b0);
        x = 8'h00;
        for (int k = 0; k < 128; k++) begin
            push_wr(8'(2 * k), 16'(k));
            send_byte(8'h00, $urandom_range(0, 2), 1'b0);
            send_byte(8'(k), $urandom_range(0, 2), 1'b0);
            x = x ^ 8'(k);
        end
        send_byte(x, 1, 1'b0);
        chk("full_done", {31'd0, done}, 32'd1);
        chk("full_err", {31'd0, err}, 32'd0);
        chk("full_words", {24'd0, words_loaded}, 32'd128);
        chk("full_q", exp_q.size(), 32'd0);

        // Reset after the third word's HI byte
        pulse_start();
        push_wr(8'h00, 16'h1122);
        push_wr(8'h02, 16'h3344);
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        send_byte(8'h33, 0, 1'b0);
        send_byte(8'h44, 0, 1'b0);
        send_byte(8'h55, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_ready", {31'd0, in_ready}, 32'd0);
        chk("mr_hold", {31'd0, cpu_hold}, 32'd0);
        chk("mr_flags", {29'd0, ins_we, done, err}, 32'd0);
        chk("mr_outs", {ins_index, instructs, words_loaded}, 32'd0);
        base = n_writes;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h66;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("mr_nowr", n_writes - base, 32'd0);
        chk("mr_q", exp_q.size(), 32'd0);
        nominal(8'h40, 1'b0);
        chk("mr_reload_done", {31'd0, done}, 32'd1);
        chk("mr_reload_q", exp_q.size(), 32'd0);

        // start during HI of the second word is ignored
        nominal(8'h40, 1'b1);
        chk("ign_done", {31'd0, done}, 32'd1);
        chk("ign_err", {31'd0, err}, 32'd0);
        chk("ign_words", {24'd0, words_loaded}, 32'd2);
        chk("ign_q", exp_q.size(), 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
